// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage scheduler.
// Contents: the scheduler state type, default transform size, and the
// pipeline latency constants that make up PIPE_DELAY.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_state_e;

  localparam int DEF_LOG2N      = 4;
  localparam int RAM_RD_LAT     = 1;
  localparam int BF_LAT         = 8;
  localparam int DEF_PIPE_DELAY = RAM_RD_LAT + BF_LAT;

endpackage

// File: rtl/fft_stage_scheduler_if.sv
// Memory-side bus of the FFT stage scheduler.
// Carries the RAM read strobe and addresses, the twiddle ROM index, and the
// write-back strobe and addresses.
//   master : driven by the scheduler
//   slave  : seen by the RAM / twiddle ROM / butterfly side
interface fft_stage_scheduler_if
  import fft_pkg::*;
#(
  parameter int LOG2N = DEF_LOG2N
);
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;

  modport master (
    output rd_en, rd_addr_a, rd_addr_b, tw_addr,
    output wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input rd_en, rd_addr_a, rd_addr_b, tw_addr,
    input wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_sched_delay.sv
// Fixed-depth shift register with synchronous active-low clear.
// Ports:
//   clk   : clock
//   rst_n : synchronous clear, active low
//   din   : word entering the line
//   dout  : word that entered DEPTH cycles earlier
module fft_sched_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fft_stage_scheduler.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT over one
// pipelined butterfly unit and a dual-port sample RAM (input bit-reversed).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : begin a transform (only honoured in IDLE)
//   busy       : high from first issue cycle through last drain cycle
//   done       : one-cycle completion pulse
//   stage      : current stage index
//   mem        : read/twiddle/write-back bus (master side)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// ISSUE | one butterfly read per cycle, k = 0..N/2-1
// DRAIN | no reads for PIPE_DELAY cycles so pending writes land first
// DONE  | done pulse, back to IDLE
module fft_stage_scheduler
  import fft_pkg::*;
#(
  parameter int LOG2N      = DEF_LOG2N,
  parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(LOG2N)-1:0] stage,
  fft_stage_scheduler_if.master    mem
);

  localparam int HALF = 1 << (LOG2N - 1);
  localparam int SW   = $clog2(LOG2N);
  localparam int KW   = LOG2N - 1;
  localparam int DW   = $clog2(PIPE_DELAY + 1);
  localparam int LW   = 1 + 2 * LOG2N;

  fft_state_e       state;
  logic [KW-1:0]    k;
  logic [DW-1:0]    dcnt;
  logic             rd_en_q;
  logic [LOG2N-1:0] rd_a_q;
  logic [LOG2N-1:0] rd_b_q;
  logic [KW-1:0]    tw_q;
  logic [LW-1:0]    wr_line;

  function automatic logic [LOG2N-1:0] calc_a(input logic [SW-1:0] s,
                                               input logic [KW-1:0] kk);
    int span;
    span = 1 << s;
    return LOG2N'(((int'(kk) >> s) * 2 * span) + (int'(kk) & (span - 1)));
  endfunction

  function automatic logic [LOG2N-1:0] calc_b(input logic [SW-1:0] s,
                                               input logic [KW-1:0] kk);
    return calc_a(s, kk) + LOG2N'(32'd1 << s);
  endfunction

  // pos scaled up so every stage indexes the same N/2-entry twiddle ROM
  function automatic logic [KW-1:0] calc_tw(input logic [SW-1:0] s,
                                             input logic [KW-1:0] kk);
    int pos;
    pos = int'(kk) & ((1 << s) - 1);
    return KW'(pos << (LOG2N - 1 - int'(s)));
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      stage   <= '0;
      dcnt    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ISSUE;
            stage   <= '0;
            k       <= '0;
            busy    <= 1'b1;
            rd_en_q <= 1'b1;
            rd_a_q  <= calc_a('0, '0);
            rd_b_q  <= calc_b('0, '0);
            tw_q    <= calc_tw('0, '0);
          end
        end
        ISSUE: begin
          if (k == KW'(HALF - 1)) begin
            state   <= DRAIN;
            dcnt    <= DW'(PIPE_DELAY);
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
          end else begin
            k       <= k + 1'b1;
            rd_a_q  <= calc_a(stage, k + 1'b1);
            rd_b_q  <= calc_b(stage, k + 1'b1);
            tw_q    <= calc_tw(stage, k + 1'b1);
          end
        end
        DRAIN: begin
          if (dcnt == DW'(1)) begin
            if (stage == SW'(LOG2N - 1)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state   <= ISSUE;
              stage   <= stage + 1'b1;
              k       <= '0;
              rd_en_q <= 1'b1;
              rd_a_q  <= calc_a(stage + 1'b1, '0);
              rd_b_q  <= calc_b(stage + 1'b1, '0);
              tw_q    <= calc_tw(stage + 1'b1, '0);
            end
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fft_sched_delay #(
    .WIDTH(LW),
    .DEPTH(PIPE_DELAY)
  ) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({rd_en_q, rd_a_q, rd_b_q}),
    .dout (wr_line)
  );

  assign mem.rd_en     = rd_en_q;
  assign mem.rd_addr_a = rd_a_q;
  assign mem.rd_addr_b = rd_b_q;
  assign mem.tw_addr   = tw_q;
  assign mem.wr_en     = wr_line[LW-1];
  assign mem.wr_addr_a = wr_line[2*LOG2N-1:LOG2N];
  assign mem.wr_addr_b = wr_line[LOG2N-1:0];

endmodule
